// File: rtl/down_counter16.sv
// Loadable 16-bit down counter built from four 4-bit slices chained by a
// ripple borrow; optional one-shot stop at zero and a registered DONE pulse.
module down_counter16 (
    input  logic        CLK,
    input  logic        nCLR,
    input  logic        nLOAD,
    input  logic        ENP,
    input  logic        ENT,
    input  logic        ONESHOT,
    input  logic [3:0]  Din,
    output logic [15:0] Dout,
    output logic        RBO,
    output logic        DONE
);

    logic [15:0] count;
    logic [15:0] count_next;
    logic [4:0]  borrow;
    logic [3:0]  slice_zero;
    logic        all_zero;
    logic        count_en;
    logic        hit_zero;

    // borrow[k] is the borrow into slice k; ENT feeds the bottom of the chain
    always_comb begin
        borrow[0] = ENT;
        for (int k = 0; k < 4; k++) begin
            slice_zero[k] = (count[4*k +: 4] == 4'h0);
            borrow[k+1]   = borrow[k] & slice_zero[k];
        end
    end

    assign all_zero = &slice_zero;
    assign count_en = ENP & ENT & ~(ONESHOT & all_zero);

    always_comb begin
        count_next = count;
        if (!nLOAD) begin
            count_next = {Din, Din, Din, Din};
        end else if (count_en) begin
            for (int k = 0; k < 4; k++) begin
                if (borrow[k]) begin
                    count_next[4*k +: 4] = count[4*k +: 4] - 4'h1;
                end
            end
        end
    end

    // Only a real count step from 0x0001 produces terminal count
    assign hit_zero = nLOAD & count_en & (count == 16'h0001);

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            count <= 16'h0000;
            DONE  <= 1'b0;
        end else begin
            count <= count_next;
            DONE  <= hit_zero;
        end
    end

    assign Dout = count;
    assign RBO  = borrow[4];

endmodule
